// File: rtl/sigmoid_lut_arbiter_pkg.sv
// Shared widths, defaults and types for the sigmoid LUT arbiter and its response FIFO.
package sigmoid_lut_arbiter_pkg;

    localparam int LUT_ADDR_W    = 8;
    localparam int LUT_FRAC_W    = 14;
    localparam int LUT_EXP_W     = 4;
    localparam int RSP_ENTRY_W   = 1 + LUT_FRAC_W + LUT_EXP_W;
    localparam int ROM_LAT_DEF   = 1;
    localparam int RSP_DEPTH_DEF = 4;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                  id;
        logic [LUT_FRAC_W-1:0] frac;
        logic [LUT_EXP_W-1:0]  exp;
    } rsp_entry_t;

endpackage

// File: rtl/sigmoid_lut_arbiter_rsp_fifo.sv
// Show-ahead synchronous response FIFO; the head entry is presented whenever non-empty.
module sigmoid_rsp_fifo
    import sigmoid_lut_arbiter_pkg::*;
#(
    parameter int WIDTH = RSP_ENTRY_W,
    parameter int DEPTH = RSP_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin arbiter sharing one sigmoid LUT between two requesters, with credit-based
// flow control so the in-order response FIFO can never overflow.
module sigmoid_lut_arbiter
    import sigmoid_lut_arbiter_pkg::*;
#(
    parameter int ROM_LAT   = ROM_LAT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [LUT_ADDR_W-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [LUT_ADDR_W-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  lut_en,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    input  logic [LUT_FRAC_W-1:0] lut_frac,
    input  logic [LUT_EXP_W-1:0]  lut_exp,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [LUT_FRAC_W-1:0] rsp_frac,
    output logic [LUT_EXP_W-1:0]  rsp_exp
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    req_id_e               prio_q;
    req_id_e               grant_id;
    logic                  grant_any;
    logic                  credit;
    logic                  accept;
    logic                  pop;
    logic [CW-1:0]         outstanding_q;
    logic [LUT_ADDR_W-1:0] lut_addr_q;
    logic [ROM_LAT-1:0]    pipe_valid;
    logic [ROM_LAT-1:0]    pipe_id;
    rsp_entry_t            push_entry;
    rsp_entry_t            head_entry;
    logic                  head_valid;

    // The pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ0;
        if (req0_valid && (prio_q == REQ0 || !req1_valid)) begin
            grant_any = 1'b1;
            grant_id  = REQ0;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = REQ1;
        end
    end

    assign credit     = !rst && (outstanding_q < CW'(RSP_DEPTH));
    assign accept     = grant_any && credit;
    assign req0_ready = accept && (grant_id == REQ0);
    assign req1_ready = accept && (grant_id == REQ1);

    assign lut_en   = accept;
    assign lut_addr = !accept ? lut_addr_q : (grant_id == REQ1) ? req1_addr : req0_addr;

    // Outstanding counts both LUT-pipeline lookups and buffered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q        <= REQ0;
            lut_addr_q    <= '0;
            outstanding_q <= '0;
        end else begin
            if (accept) begin
                prio_q     <= (grant_id == REQ0) ? REQ1 : REQ0;
                lut_addr_q <= lut_addr;
            end
            case ({accept, pop})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Clearing the valids on reset is what drops LUT data still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_id    <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_id[0]    <= grant_id;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    assign push_entry.id   = pipe_id[ROM_LAT-1];
    assign push_entry.frac = lut_frac;
    assign push_entry.exp  = lut_exp;

    sigmoid_rsp_fifo #(
        .WIDTH (RSP_ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (pipe_valid[ROM_LAT-1]),
        .push_data  (push_entry),
        .pop        (pop),
        .head_data  (head_entry),
        .head_valid (head_valid)
    );

    assign rsp_valid = head_valid && !rst;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? head_entry.id   : 1'b0;
    assign rsp_frac  = rsp_valid ? head_entry.frac : '0;
    assign rsp_exp   = rsp_valid ? head_entry.exp  : '0;

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Self-checking bench: vector table for single lookups, hand sequences for arbitration,
// backpressure and reset, and a scoreboard checking every response in accept order.
module tb_sigmoid_lut_arbiter;

    typedef struct packed {
        logic        id;
        logic [13:0] frac;
        logic [3:0]  exp;
    } sb_t;

    typedef struct {
        logic        id;
        logic [7:0]  addr;
        logic [13:0] frac;
        logic [3:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [7:0]  req0_addr;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_addr;
    logic        req1_ready;
    logic        lut_en;
    logic [7:0]  lut_addr;
    logic [13:0] lut_frac = '0;
    logic [3:0]  lut_exp = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [13:0] rsp_frac;
    logic [3:0]  rsp_exp;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    logic hold_valid = 1'b0;
    sb_t  hold_entry;
    vec_t vecs[5];

    sigmoid_lut_arbiter #(.ROM_LAT(1), .RSP_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .lut_en     (lut_en),
        .lut_addr   (lut_addr),
        .lut_frac   (lut_frac),
        .lut_exp    (lut_exp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_frac   (rsp_frac),
        .rsp_exp    (rsp_exp)
    );

    always #5 clk = ~clk;

    // One-cycle LUT model: frac = addr*3, exp = addr[3:0].
    always @(posedge clk) begin
        if (lut_en) begin
            lut_frac <= 14'(lut_addr) * 14'd3;
            lut_exp  <= lut_addr[3:0];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic [7:0] a0, input logic v1,
                                  input logic [7:0] a1, input logic rr);
        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
        rsp_ready  = rr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (8) next_cycle();
        check_output("drain_sb_empty", 32'(sb.size()), 0);
        check_output("drain_rsp_valid", 32'(rsp_valid), 0);
    endtask

    // Scoreboard: accepts push expected entries, responses pop and compare in order.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            sb.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check_output("stall_valid", 32'(rsp_valid), 1);
                check_output("stall_payload", 32'({rsp_id, rsp_frac, rsp_exp}), 32'(hold_entry));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got id=%0d frac=%0h, required no response",
                             rsp_id, rsp_frac);
                end else begin
                    e = sb.pop_front();
                    check_output("sb_id", 32'(rsp_id), 32'(e.id));
                    check_output("sb_frac", 32'(rsp_frac), 32'(e.frac));
                    check_output("sb_exp", 32'(rsp_exp), 32'(e.exp));
                end
            end
            hold_valid = rsp_valid && !rsp_ready;
            hold_entry = {rsp_id, rsp_frac, rsp_exp};
            if (req0_ready && req1_ready) begin
                check_output("one_hot_ready", 32'({req0_ready, req1_ready}), 32'b01);
            end
            if (req0_valid && req0_ready) begin
                check_output("lut_addr_req0", 32'(lut_addr), 32'(req0_addr));
                sb.push_back('{1'b0, 14'(req0_addr) * 14'd3, req0_addr[3:0]});
            end else if (req1_valid && req1_ready) begin
                check_output("lut_addr_req1", 32'(lut_addr), 32'(req1_addr));
                sb.push_back('{1'b1, 14'(req1_addr) * 14'd3, req1_addr[3:0]});
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 8'h10, 14'h030, 4'h0};
        vecs[1] = '{1'b0, 8'hFF, 14'h2FD, 4'hF};
        vecs[2] = '{1'b1, 8'hAB, 14'h201, 4'hB};
        vecs[3] = '{1'b0, 8'h00, 14'h000, 4'h0};
        vecs[4] = '{1'b1, 8'h55, 14'h0FF, 4'h5};

        // Reset with a requester already valid: nothing may be granted.
        rst = 1'b1;
        apply_stimulus(1'b1, 8'h77, 1'b1, 8'h66, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_output("rst_req0_ready", 32'(req0_ready), 0);
            check_output("rst_req1_ready", 32'(req1_ready), 0);
            check_output("rst_lut_en", 32'(lut_en), 0);
            check_output("rst_rsp_valid", 32'(rsp_valid), 0);
            next_cycle();
        end
        rst = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_output("post_rst_lut_addr", 32'(lut_addr), 0);
        check_output("post_rst_payload", 32'({rsp_id, rsp_frac, rsp_exp}), 0);
        next_cycle();

        // Single lookups: grant and LUT drive in t, address held in t+1, response in t+2.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].id) apply_stimulus(1'b0, 8'h00, 1'b1, vecs[i].addr, 1'b1);
            else            apply_stimulus(1'b1, vecs[i].addr, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            check_output("vec_ready", 32'(vecs[i].id ? req1_ready : req0_ready), 1);
            check_output("vec_lut_en", 32'(lut_en), 1);
            check_output("vec_lut_addr", 32'(lut_addr), 32'(vecs[i].addr));
            next_cycle();
            apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            check_output("vec_idle_lut_en", 32'(lut_en), 0);
            check_output("vec_lut_addr_hold", 32'(lut_addr), 32'(vecs[i].addr));
            check_output("vec_early_rsp", 32'(rsp_valid), 0);
            next_cycle();
            @(negedge clk);
            check_output("vec_rsp_valid", 32'(rsp_valid), 1);
            check_output("vec_rsp_id", 32'(rsp_id), 32'(vecs[i].id));
            check_output("vec_rsp_frac", 32'(rsp_frac), 32'(vecs[i].frac));
            check_output("vec_rsp_exp", 32'(rsp_exp), 32'(vecs[i].exp));
            next_cycle();
        end

        // Contention: the last grant went to req1, so grants alternate starting with req0.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
            @(negedge clk);
            check_output("rr_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
            check_output("rr_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
            if (i >= 2) check_output("rr_throughput", 32'(rsp_valid), 1);
            next_cycle();
        end
        drain();

        // Backpressure: four accepts fill the credit, then a single pop frees exactly one.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, (i < 4) ? 8'(8'h20 + i) : 8'h24, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            check_output("bp_accept", 32'(req0_ready), 32'(i < 4));
            next_cycle();
        end
        apply_stimulus(1'b1, 8'h24, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_output("bp_pop_valid", 32'(rsp_valid), 1);
        check_output("bp_pop_frac", 32'(rsp_frac), 32'h60);
        check_output("bp_no_same_cycle_accept", 32'(req0_ready), 0);
        next_cycle();
        apply_stimulus(1'b1, 8'h24, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_output("bp_refill_accept", 32'(req0_ready), 1);
        next_cycle();
        apply_stimulus(1'b1, 8'h25, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_output("bp_full_again", 32'(req0_ready), 0);
        next_cycle();

        // From a full FIFO, stream with pushes and pops overlapping; head must never bubble.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, (i <= 1) ? 8'h30 : 8'(8'h30 + i - 1), 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            check_output("pp_accept", 32'(req0_ready), 32'(i != 0));
            check_output("pp_rsp_valid", 32'(rsp_valid), 1);
            next_cycle();
        end
        drain();

        // Reset with three buffered and one in the LUT: all discarded, pointer back on req0.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            check_output("mid_fill_accept", 32'(req0_ready), 1);
            next_cycle();
        end
        rst = 1'b1;
        apply_stimulus(1'b1, 8'h50, 1'b1, 8'h60, 1'b1);
        @(negedge clk);
        check_output("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check_output("mid_rst_ready", 32'({req0_ready, req1_ready}), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("after_rst_rsp_valid", 32'(rsp_valid), 0);
        check_output("after_rst_req0_ready", 32'(req0_ready), 1);
        check_output("after_rst_req1_ready", 32'(req1_ready), 0);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b1, 8'h61, 1'b1);
        @(negedge clk);
        check_output("after_rst_lone_req1", 32'(req1_ready), 1);
        check_output("after_rst_no_stale", 32'(rsp_valid), 0);
        next_cycle();
        drain();

        // Lone req1 while the pointer favours req0: granted every cycle.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 8'(8'h70 + i), 1'b1);
            @(negedge clk);
            check_output("lone_req1_ready", 32'(req1_ready), 1);
            next_cycle();
        end
        drain();

        // A withdrawn req0 that never handshakes must leave the pointer on req0.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 8'(8'h80 + i), 1'b0);
            @(negedge clk);
            check_output("wd_fill_req1", 32'(req1_ready), 1);
            next_cycle();
        end
        repeat (2) begin
            apply_stimulus(1'b1, 8'h90, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            check_output("wd_no_credit", 32'(req0_ready), 0);
            next_cycle();
        end
        drain();
        apply_stimulus(1'b1, 8'h91, 1'b1, 8'h92, 1'b1);
        @(negedge clk);
        check_output("wd_ptr_req0", 32'(req0_ready), 1);
        check_output("wd_ptr_req1", 32'(req1_ready), 0);
        next_cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
